// File: rtl/seq_slice_sub_ctrl_pkg.sv
// seq_sub_pkg: shared types and sizing helpers for the sliced subtract
// controller.
//   seq_state_t : controller state encoding (2 bits)
//   calc_ns     : number of K-bit slices in a G-bit operand
//   idx_width   : width of the slice index counter, never less than 1
package seq_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic int calc_ns(input int g, input int k);
    return g / k;
  endfunction

  function automatic int idx_width(input int ns);
    return (ns <= 1) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/seq_slice_sub_ctrl_slice.sv
// sub_slice: purely combinational K-bit ripple subtractor built from full
// subtractors.
//   x  [K] : minuend field
//   y  [K] : subtrahend field
//   bi     : borrow into bit 0
//   d  [K] : x - y - bi (mod 2^K)
//   bo     : borrow out of bit K-1
module sub_slice #(
  parameter int K = 8
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         bi,
  output logic [K-1:0] d,
  output logic         bo
);

  logic [K:0] brw;

  assign brw[0] = bi;

  for (genvar i = 0; i < K; i++) begin : g_fs
    assign d[i]     = x[i] ^ y[i] ^ brw[i];
    // borrow when x < y + borrow at this bit position
    assign brw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
  end

  assign bo = brw[K];

endmodule

// File: rtl/seq_slice_sub_ctrl.sv
// seq_slice_sub_ctrl: computes a - b - bin over G bits by stepping one K-bit
// subtractor slice across the operands, LSB slice first, one slice per clock.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled in IDLE or DONE only
//   a, b   : G-bit operands, captured on an accepted start
//   bin    : borrow-in, captured on an accepted start
//   busy   : high while slices are being processed
//   done   : one-cycle pulse, diff/bout valid from this cycle
//   diff   : registered G-bit difference, updated only on the final slice
//   bout   : registered borrow-out of the MSB slice
//   ovf    : registered signed overflow (only with SIGNED_OVF_EN defined)
// Optional feature macro: SIGNED_OVF_EN adds the ovf output.
//
// state | meaning
// IDLE  | waiting for start, last result held
// RUN   | one slice processed per edge, idx selects the slice
// DONE  | result just written, done pulse, start accepted back-to-back
module seq_slice_sub_ctrl
  import seq_sub_pkg::*;
#(
  parameter int G = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
`ifdef SIGNED_OVF_EN
  output logic         ovf,
`endif
  output logic [G-1:0] diff,
  output logic         bout
);

  localparam int NS = calc_ns(G, K);
  localparam int IW = idx_width(NS);

  seq_state_t     state, state_nxt;
  logic [IW-1:0]  idx;
  logic           borrow;
  logic [G-1:0]   a_r, b_r;
  logic [G-1:0]   work;
  logic [G-1:0]   work_nxt;
  logic [K-1:0]   sl_x, sl_y, sl_d;
  logic           sl_bo;
  logic           capture;
  logic           last;

  assign last = (idx == IW'(NS - 1));

  // route the current slice fields into the shared slice
  always_comb begin
    sl_x     = '0;
    sl_y     = '0;
    work_nxt = work;
    for (int i = 0; i < NS; i++) begin
      if (idx == IW'(i)) begin
        sl_x = a_r[i*K +: K];
        sl_y = b_r[i*K +: K];
        work_nxt[i*K +: K] = sl_d;
      end
    end
  end

  sub_slice #(.K(K)) u_slice (
    .x  (sl_x),
    .y  (sl_y),
    .bi (borrow),
    .d  (sl_d),
    .bo (sl_bo)
  );

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      borrow <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      work   <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (capture) begin
      a_r    <= a;
      b_r    <= b;
      borrow <= bin;
      idx    <= '0;
    end else if (state == ST_RUN) begin
      work   <= work_nxt;
      borrow <= sl_bo;
      if (last) begin
        idx  <= '0;
        diff <= work_nxt;
        bout <= sl_bo;
`ifdef SIGNED_OVF_EN
        // operands of opposite sign and result sign differs from minuend
        ovf  <= (a_r[G-1] != b_r[G-1]) && (work_nxt[G-1] != a_r[G-1]);
`endif
      end else begin
        idx  <= idx + IW'(1);
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_slice_sub_ctrl.sv
module tb_seq_slice_sub_ctrl;

  localparam int G = 32;
  localparam int K = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [G-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [G-1:0] diff;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  seq_slice_sub_ctrl #(.G(G), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef SIGNED_OVF_EN
    .ovf   (ovf),
`endif
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // waits edge by edge (sampling #1 after) until done, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // single request: start for one cycle, check latency, result, pulse width
  task automatic run_op(input string tag, input logic [G-1:0] va, input logic [G-1:0] vb,
                        input logic vbin, input logic [G-1:0] ed, input logic eb);
    int cyc;
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'd4);
    chk({tag, "_diff"}, 64'(diff), 64'(ed));
    chk({tag, "_bout"}, 64'(bout), 64'(eb));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(diff), 64'(ed));
  endtask

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",  32'd15,         32'd9,          1'b1, 32'd5,          1'b0);
    run_op("neg",    32'd5,          32'd9,          1'b0, 32'hFFFF_FFFC,  1'b1);
    run_op("bnd01",  32'h0000_0100,  32'd1,          1'b0, 32'h0000_00FF,  1'b0);
    run_op("allbrw", 32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1);
    run_op("equal",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd0,          1'b0);
    run_op("mix",    32'h1234_5678,  32'h0102_0304,  1'b0, 32'h1132_5374,  1'b0);

    // start held through RUN: ignored until DONE, then accepted back-to-back
    @(negedge clk);
    a = 32'd10; b = 32'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd100; b = 32'd1;
    wait_done(cyc);
    chk("b2b_lat1", 64'(cyc), 64'd4);
    chk("b2b_diff1", 64'(diff), 64'd7);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rerun", 64'(busy), 64'd1);
    chk("b2b_hold", 64'(diff), 64'd7);
    wait_done(cyc);
    chk("b2b_lat2", 64'(cyc), 64'd4);
    chk("b2b_diff2", 64'(diff), 64'd99);
    @(posedge clk); #1;
    chk("b2b_idle", 64'(busy), 64'd0);

    // asynchronous reset during the second RUN cycle
    @(negedge clk);
    a = 32'd50; b = 32'd8; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_diff", 64'(diff), 64'd0);
    chk("arst_bout", 64'(bout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("arst_nodone", 64'(seen), 64'd0);
    run_op("post_rst", 32'd50, 32'd8, 1'b0, 32'd42, 1'b0);

`ifdef SIGNED_OVF_EN
    run_op("ovf1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0);
    chk("ovf1_flag", 64'(ovf), 64'd1);
    run_op("ovf0", 32'd5, 32'd9, 1'b0, 32'hFFFF_FFFC, 1'b1);
    chk("ovf0_flag", 64'(ovf), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
